// File: rtl/run_ctrl_if.sv
// run_ctrl_if -- bundle of the run-control user inputs and CPU-side outputs.
//
// Signals:
//   cont      run switch, asynchronous to clk100m (1 = continuous run)
//   step      single-step pushbutton, asynchronous to clk100m
//   cpu_en    one-cycle clock-enable to the multicycle CPU
//   running   high while the controller is in continuous run
//   step_cnt  number of cpu_en pulses issued (16-bit, wrapping)
//
// Modports:
//   master  drives the switch/button side, observes the outputs
//   slave   the run_ctrl block itself
interface run_ctrl_if;
    logic        cont;
    logic        step;
    logic        cpu_en;
    logic        running;
    logic [15:0] step_cnt;

    modport master (
        output cont,
        output step,
        input  cpu_en,
        input  running,
        input  step_cnt
    );

    modport slave (
        input  cont,
        input  step,
        output cpu_en,
        output running,
        output step_cnt
    );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl -- run/step controller producing a clock-enable for a multicycle CPU.
//
// The cont switch and step button are synchronized (2 flops) and debounced
// independently. A debounced step press issues exactly one cpu_en pulse;
// a debounced cont=1 enters continuous run, where a prescaler issues one
// cpu_en pulse every RUN_DIV cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronized input must disagree with its
//                    debounced value before the debounced value follows (>=1)
//   RUN_DIV          clk100m cycles between cpu_en pulses in run mode (>=1)
//
// Ports:
//   clk100m  system clock (single domain)
//   rst      asynchronous active-high reset
//   bus      run_ctrl_if.slave: cont, step in; cpu_en, running, step_cnt out
//
// Build option:
//   RUN_CTRL_STEP_CNT_EN  when defined the step_cnt pulse counter is built;
//                         otherwise step_cnt is tied to 16'h0000.
module run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000
) (
    input  logic           clk100m,
    input  logic           rst,
    run_ctrl_if.slave      bus
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(RUN_DIV - 1);

    // Input index 0 = cont, 1 = step.
    logic [1:0] raw_in;
    logic [1:0] db_val;

    assign raw_in = {bus.step, bus.cont};

    // ------------------------------------------------------------------
    // Per-input synchronizer + debounce
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_in
            logic          sync1_q;
            logic          sync2_q;
            logic          db_q;
            logic          db_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Counter runs only while the synchronized level disagrees with
            // the debounced value; any agreeing cycle restarts the count.
            always_comb begin
                db_d  = db_q;
                cnt_d = '0;
                if (sync2_q != db_q) begin
                    if (cnt_q == DB_LAST) begin
                        db_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk100m or posedge rst) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    db_q    <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_in[gi];
                    sync2_q <= sync1_q;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign db_val[gi] = db_q;
        end
    endgenerate

    logic cont_db;
    logic step_db;
    logic step_dly_q;
    logic step_rise;

    assign cont_db   = db_val[0];
    assign step_db   = db_val[1];
    // Edge detect on the debounced level: one pulse per press however long held.
    assign step_rise = step_db & ~step_dly_q;

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            step_dly_q <= 1'b0;
        end else begin
            step_dly_q <= step_db;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          cpu_en_q;
    logic          cpu_en_d;
    logic          running_q;
    logic          running_d;

    // State register (outputs are registered alongside so they are glitch-free).
    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
        end
    end

    // Next state. Run takes priority over a coincident step press; step
    // presses seen outside IDLE are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cont_db) begin
                    state_d = S_RUN;
                end else if (step_rise) begin
                    state_d = S_STEP;
                end
            end
            S_STEP:  state_d = S_IDLE;
            S_RUN: begin
                if (!cont_db) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values, decoded from the state being entered so the
    // registered outputs line up with the registered state.
    always_comb begin
        presc_d   = '0;
        cpu_en_d  = 1'b0;
        running_d = (state_d == S_RUN);
        case (state_d)
            S_STEP: cpu_en_d = 1'b1;
            S_RUN: begin
                // Prescaler restarts at 0 on every RUN entry.
                if (state_q == S_RUN) begin
                    presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
                end
                cpu_en_d = (presc_d == PS_LAST);
            end
            default: ;
        endcase
    end

    assign bus.cpu_en  = cpu_en_q;
    assign bus.running = running_q;

    // ------------------------------------------------------------------
    // Pulse counter
    // ------------------------------------------------------------------
`ifdef RUN_CTRL_STEP_CNT_EN
    logic [15:0] step_cnt_q;
    logic [15:0] step_cnt_d;

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (cpu_en_d) begin
            step_cnt_d = step_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            step_cnt_q <= 16'h0000;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign bus.step_cnt = step_cnt_q;
`else
    assign bus.step_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- directed bench for run_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=3).
// Expected cpu_en pulses (cycle number and step_cnt) are queued when the
// stimulus is applied; a monitor pops and compares each observed pulse.
module tb_run_ctrl;

    localparam int DB  = 4;
    localparam int DIV = 3;
`ifdef RUN_CTRL_STEP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk100m = 1'b0;
    logic rst     = 1'b0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    typedef struct {
        int edge_no;
        int cnt;
    } exp_t;

    exp_t sb[$];

    run_ctrl_if bus ();

    run_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (DIV)
    ) dut (
        .clk100m(clk100m),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk100m = ~clk100m;

    always @(posedge clk100m) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int cnt_exp();
        return CNT_ON ? (exp_cnt & 16'hFFFF) : 0;
    endfunction

    task automatic push_pulse(input int e);
        exp_t x;
        exp_cnt++;
        x.edge_no = e;
        x.cnt     = cnt_exp();
        sb.push_back(x);
    endtask

    // Run-mode pulses every DIV cycles from first up to last (inclusive).
    task automatic push_run(input int first, input int last);
        for (int e = first; e <= last; e += DIV) push_pulse(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk100m);
    endtask

    // Scoreboard monitor: every cpu_en pulse must match the queue head.
    always @(negedge clk100m) begin
        if (mon_en && !rst && bus.cpu_en !== 1'b0) begin
            if (sb.size() == 0) begin
                check("pulse_expected", 0, 1);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("pulse_cycle", cyc, x.edge_no);
                check("pulse_cnt", {16'h0, bus.step_cnt}, x.cnt);
                $display("pulse: cycle=%0d step_cnt=%0d (expected cycle=%0d cnt=%0d)",
                         cyc, bus.step_cnt, x.edge_no, x.cnt);
            end
        end
    end

    initial begin
        int n;
        int m;
        int r;

        bus.cont = 1'b0;
        bus.step = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_cpu_en", {31'h0, bus.cpu_en}, 0);
        check("rst_running", {31'h0, bus.running}, 0);
        check("rst_step_cnt", {16'h0, bus.step_cnt}, 0);
        wait_to(3);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Short glitch on step: never debounced, no pulse
        wait_to(5);
        n = cyc;
        bus.step = 1'b1;
        wait_to(n + 3);
        bus.step = 1'b0;
        wait_to(n + 15);
        check("glitch_drained", sb.size(), 0);
        check("glitch_cnt", {16'h0, bus.step_cnt}, 0);
        check("glitch_running", {31'h0, bus.running}, 0);

        // Step held 20 cycles: exactly one pulse
        n = cyc;
        bus.step = 1'b1;
        push_pulse(n + 2 + DB + 1);
        for (int i = 1; i <= 20; i++) begin
            wait_to(n + i);
            check("step_running", {31'h0, bus.running}, 0);
        end
        bus.step = 1'b0;
        wait_to(n + 32);
        check("step_drained", sb.size(), 0);
        check("step_cnt_after_step", {16'h0, bus.step_cnt}, cnt_exp());

        // Continuous run for 30 cycles
        n = cyc;
        m = n + 30;
        bus.cont = 1'b1;
        push_run(n + 2 + DB + 1 + (DIV - 1), m + 2 + DB);
        wait_to(n + 6);
        check("run_entry_before", {31'h0, bus.running}, 0);
        wait_to(n + 7);
        check("run_entry", {31'h0, bus.running}, 1);
        wait_to(m);
        bus.cont = 1'b0;
        wait_to(m + 6);
        check("run_exit_before", {31'h0, bus.running}, 1);
        wait_to(m + 7);
        check("run_exit", {31'h0, bus.running}, 0);
        wait_to(m + 15);
        check("run_drained", sb.size(), 0);
        check("run_cnt", {16'h0, bus.step_cnt}, cnt_exp());

        // cont and step together from IDLE: run wins, no step pulse
        n = cyc;
        m = n + 12;
        bus.cont = 1'b1;
        bus.step = 1'b1;
        push_run(n + 9, m + 6);
        wait_to(n + 7);
        check("both_running", {31'h0, bus.running}, 1);
        wait_to(m);
        bus.cont = 1'b0;
        bus.step = 1'b0;
        wait_to(m + 7);
        check("both_exit", {31'h0, bus.running}, 0);
        wait_to(m + 15);
        check("both_drained", sb.size(), 0);
        check("both_cnt", {16'h0, bus.step_cnt}, cnt_exp());

        // Reset to clear the counter, then run up to five pulses
        @(negedge clk100m);
        rst = 1'b1;
        #1;
        check("rst2_step_cnt", {16'h0, bus.step_cnt}, 0);
        exp_cnt = 0;
        @(negedge clk100m);
        rst = 1'b0;
        n = cyc;
        bus.cont = 1'b1;
        push_run(n + 9, n + 21);
        wait_to(n + 21);
        check("mid_run_cnt", {16'h0, bus.step_cnt}, CNT_ON ? 5 : 0);
        check("mid_run_cpu_en", {31'h0, bus.cpu_en}, 1);
        // Reset lands while cpu_en is high: everything drops at once
        #2 rst = 1'b1;
        #1;
        check("abort_cpu_en", {31'h0, bus.cpu_en}, 0);
        check("abort_running", {31'h0, bus.running}, 0);
        check("abort_step_cnt", {16'h0, bus.step_cnt}, 0);
        exp_cnt = 0;
        wait_to(n + 23);
        rst = 1'b0;
        r = n + 23;
        m = r + 10;
        push_run(r + 9, m + 6);
        wait_to(r + 6);
        check("reenter_before", {31'h0, bus.running}, 0);
        wait_to(r + 7);
        check("reenter", {31'h0, bus.running}, 1);
        wait_to(m);
        bus.cont = 1'b0;
        wait_to(m + 15);
        check("reenter_drained", sb.size(), 0);
        check("reenter_cnt", {16'h0, bus.step_cnt}, cnt_exp());
        check("final_running", {31'h0, bus.running}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive clk100m cycles an input must hold a new level before the debounced value changes (>=1).
REQ-002 The block SHALL have parameter RUN_DIV, default 50000000, meaning clk100m cycles between CPU enable pulses in continuous mode (>=1).
REQ-003 The block SHALL have port clk100m, input, 1, system clock (100 MHz); single clock domain.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port cont, input, 1, asynchronous run switch (1 = continuous run).
REQ-006 The block SHALL have port step, input, 1, asynchronous single-step pushbutton.
REQ-007 The block SHALL have port cpu_en, output, 1, clock-enable to multicycle CPU; advance one CPU cycle when high.
REQ-008 The block SHALL have port running, output, 1, high while the FSM is in RUN.
REQ-009 The block SHALL have port step_cnt, output, 16, count of cpu_en pulses issued.

Function
REQ-010 cont and step SHALL each pass a 2-flop synchronizer before any other logic.
REQ-011 Each synchronized input SHALL have its own debounce counter; the debounced value takes the synchronized level after DEBOUNCE_CYCLES consecutive cycles of disagreement, and the counter clears on any agreement cycle.
REQ-012 step_rise SHALL be a one-cycle pulse on a debounced-step 0->1 transition; holding step SHALL yield exactly one pulse.
REQ-013 FSM states SHALL be IDLE, STEP and RUN.
REQ-014 IDLE: cpu_en=0; if debounced cont=1 go to RUN; else if step_rise go to STEP.
REQ-015 STEP: cpu_en=1 for exactly one cycle; then unconditionally IDLE.
REQ-016 RUN: prescaler counts 0..RUN_DIV-1 and wraps; cpu_en=1 only in the cycle the prescaler equals RUN_DIV-1; RUN_DIV=1 gives cpu_en every RUN cycle.
REQ-017 RUN: debounced cont=0 SHALL go to IDLE next cycle with prescaler cleared to 0; no cpu_en in the exit cycle.
REQ-018 step_rise SHALL be ignored in RUN and in STEP (not queued).
REQ-019 Simultaneous debounced cont=1 and step_rise in IDLE: RUN wins, step discarded.
REQ-020 Prescaler SHALL start from 0 on every RUN entry; first run pulse comes RUN_DIV cycles after entry.
REQ-021 running SHALL be a registered decode of state==RUN.
REQ-022 step_cnt SHALL increment by 1 in the cycle cpu_en=1 is registered, wrapping 0xFFFF->0x0000.
REQ-023 cpu_en SHALL be driven from a flop (glitch-free); never high for 2+ consecutive cycles unless RUN_DIV=1.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, cpu_en=0, running=0, step_cnt=0, prescaler=0, synchronizers=0, debounced values=0, debounce counters=0.
REQ-025 Reset asserted mid-STEP or mid-RUN SHALL abort with no further cpu_en pulse; after release, a held-high cont re-enters RUN only after full debounce.

Configuration
REQ-026 Macro RUN_CTRL_STEP_CNT_EN: when defined, step_cnt behaves per REQ-022; when undefined, the counter is not built and step_cnt SHALL be constant 16'h0000; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=3, RUN_CTRL_STEP_CNT_EN defined)
REQ-027 step high 20 cycles, cont=0 -> exactly one cpu_en pulse, step_cnt=1, running=0 throughout.
REQ-028 step glitch high 3 cycles then low -> no cpu_en, step_cnt=0.
REQ-029 cont high 30 cycles -> running=1 after sync+debounce, cpu_en every 3rd cycle thereafter, step_cnt equals pulse count; cont low -> running=0 and pulses stop after debounce.
REQ-030 cont and step raised same cycle from IDLE -> RUN entered, no STEP pulse, first cpu_en 3 cycles after RUN entry.
REQ-031 rst pulsed mid-RUN with step_cnt=5 -> cpu_en=0, running=0, step_cnt=0 same cycle; cont still high -> RUN re-entered only after 2+4 cycles.
REQ-032 Macro undefined, repeat REQ-029 -> identical cpu_en/running, step_cnt stays 0.
